fetch_miss_refill_unit: RTL and testbench

- Sits beside the instruction fetch unit, consuming its miss outputs (isCacheMiss_o, newTag_o, newIndex_o, newOffset_o).
- Issues a line-aligned request to the memory side, then assembles the multi-beat response into one cacheline.
- Drives the fetch unit's cache update inputs (newTag_i, newIndex_i, newOffset_i, newCacheline_i, cacheUpdateEnable_i).
- Holds one active refill plus one pending miss. Merges duplicate misses to the line in flight.

---
 rtl/fetch_miss_refill_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_miss_refill_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_miss_refill_unit.sv
// Refill engine beside the instruction fetch unit. It takes one cache miss,
// issues a line-aligned memory request, assembles the multi-beat response
// into a full cacheline and strobes it into the cache. One refill is active
// at a time, one further miss can wait in a pending slot, and duplicate
// misses to a line already being handled are merged.
module fetch_miss_refill_unit #(
    parameter int offsetSize        = 5,
    parameter int indexSize         = 8,
    parameter int tagSize           = 64 - offsetSize - indexSize,
    parameter int cachelineSizeBits = (2 ** offsetSize) * 8,
    parameter int memBusBits        = 64
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         missValid_i,
    input  logic [tagSize-1:0]           missTag_i,
    input  logic [indexSize-1:0]         missIndex_i,
    input  logic [offsetSize-1:0]        missOffset_i,
    output logic                         busy_o,
    output logic                         missDropped_o,
    output logic                         memReqValid_o,
    input  logic                         memReqReady_i,
    output logic [63:0]                  memReqAddr_o,
    input  logic                         memRespValid_i,
    input  logic [memBusBits-1:0]        memRespData_i,
    output logic [tagSize-1:0]           newTag_o,
    output logic [indexSize-1:0]         newIndex_o,
    output logic [offsetSize-1:0]        newOffset_o,
    output logic [cachelineSizeBits-1:0] newCacheline_o,
    output logic                         cacheUpdateEnable_o
);

    localparam int num_beats = cachelineSizeBits / memBusBits;
    localparam int beat_w    = $clog2(num_beats);

    typedef enum logic [1:0] {IDLE, REQ, RESP, WRITE} state_t;

    state_t                       state, next_state;
    logic [tagSize-1:0]           act_tag, pend_tag;
    logic [indexSize-1:0]         act_index, pend_index;
    logic [offsetSize-1:0]        act_offset, pend_offset;
    logic                         pend_valid;
    logic [beat_w-1:0]            beat_cnt;
    logic [cachelineSizeBits-1:0] line_buf, line_next;

    logic hit_active, hit_pending, new_distinct;
    logic launch_new, store_pending, load_from_pend, drop, last_beat;

    // Classify an incoming miss against the line in flight and the pending slot.
    always_comb begin
        hit_active     = (missTag_i == act_tag) && (missIndex_i == act_index);
        hit_pending    = pend_valid && (missTag_i == pend_tag) && (missIndex_i == pend_index);
        new_distinct   = missValid_i && (state != IDLE) && !hit_active && !hit_pending;
        // A miss in WRITE with nothing pending goes straight to the active slot,
        // otherwise it would sit in the pending slot after we return to IDLE.
        launch_new     = missValid_i && ((state == IDLE) ||
                                         ((state == WRITE) && !pend_valid && !hit_active));
        load_from_pend = (state == WRITE) && pend_valid;
        store_pending  = new_distinct && (((state != WRITE) && !pend_valid) || load_from_pend);
        drop           = new_distinct && (state != WRITE) && pend_valid;
        last_beat      = (state == RESP) && memRespValid_i && (beat_cnt == beat_w'(num_beats - 1));
    end

    // Line buffer with the current beat inserted; beat 0 lands in the top bits.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        line_next = line_buf;
        for (int b = 0; b < num_beats; b++) begin
            if (beat_cnt == beat_w'(b)) begin
                line_next[cachelineSizeBits-1-b*memBusBits -: memBusBits] = memRespData_i;
            end
        end
    end

    // State register.
    always_ff @(posedge clock_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset_i) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (missValid_i) next_state = REQ;
            REQ:     if (memReqReady_i) next_state = RESP;
            RESP:    if (last_beat) next_state = WRITE;
            WRITE:   next_state = (pend_valid || launch_new) ? REQ : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Active/pending miss registers, beat counter, line buffer and update outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            // NOTE: the line buffer is cleared on reset so an abandoned refill
            // can never leak partial data into a later line.
            act_tag        <= '0;
            act_index      <= '0;
            act_offset     <= '0;
            pend_valid     <= 1'b0;
            pend_tag       <= '0;
            pend_index     <= '0;
            pend_offset    <= '0;
            beat_cnt       <= '0;
            line_buf       <= '0;
            newTag_o       <= '0;
            newIndex_o     <= '0;
            newOffset_o    <= '0;
            newCacheline_o <= '0;
        end else begin
            if (launch_new) begin
                act_tag    <= missTag_i;
                act_index  <= missIndex_i;
                act_offset <= missOffset_i;
            end else if (load_from_pend) begin
                act_tag    <= pend_tag;
                act_index  <= pend_index;
                act_offset <= pend_offset;
            end

            if (store_pending) begin
                pend_valid  <= 1'b1;
                pend_tag    <= missTag_i;
                pend_index  <= missIndex_i;
                pend_offset <= missOffset_i;
            end else if (load_from_pend) begin
                pend_valid <= 1'b0;
            end

            if ((state == REQ) && memReqReady_i) begin
                beat_cnt <= '0;
            end else if ((state == RESP) && memRespValid_i) begin
                line_buf <= line_next;
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end

            if (last_beat) begin
                newTag_o       <= act_tag;
                newIndex_o     <= act_index;
                newOffset_o    <= act_offset;
                newCacheline_o <= line_next;
            end
        end
    end

    // Outputs decoded from state and the active miss.
    always_comb begin
        busy_o              = (state != IDLE);
        memReqValid_o       = (state == REQ);
        cacheUpdateEnable_o = (state == WRITE);
        memReqAddr_o        = {act_tag, act_index, {offsetSize{1'b0}}};
        missDropped_o       = drop && !reset_i;
    end

endmodule

// File: tb/tb_fetch_miss_refill_unit.sv
// Directed bench for fetch_miss_refill_unit: single refill, request
// backpressure, merge/pending/drop, drain-with-new-miss, reset mid-refill
// and stray response beats, all against hand-computed values.
module tb_fetch_miss_refill_unit;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          missValid_i;
    logic [50:0]   missTag_i;
    logic [7:0]    missIndex_i;
    logic [4:0]    missOffset_i;
    logic          busy_o, missDropped_o, memReqValid_o, memReqReady_i;
    logic [63:0]   memReqAddr_o;
    logic          memRespValid_i;
    logic [63:0]   memRespData_i;
    logic [50:0]   newTag_o;
    logic [7:0]    newIndex_o;
    logic [4:0]    newOffset_o;
    logic [255:0]  newCacheline_o;
    logic          cacheUpdateEnable_o;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    logic [50:0] strobe_tags [16];
    int base;

    fetch_miss_refill_unit dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .missValid_i(missValid_i), .missTag_i(missTag_i),
        .missIndex_i(missIndex_i), .missOffset_i(missOffset_i),
        .busy_o(busy_o), .missDropped_o(missDropped_o),
        .memReqValid_o(memReqValid_o), .memReqReady_i(memReqReady_i),
        .memReqAddr_o(memReqAddr_o),
        .memRespValid_i(memRespValid_i), .memRespData_i(memRespData_i),
        .newTag_o(newTag_o), .newIndex_o(newIndex_o), .newOffset_o(newOffset_o),
        .newCacheline_o(newCacheline_o), .cacheUpdateEnable_o(cacheUpdateEnable_o)
    );

    always #5 clock_i = ~clock_i;

    // Log every update strobe and the tag it carried.
    always @(negedge clock_i) begin
        if (cacheUpdateEnable_o) begin
            strobe_tags[strobe_cnt % 16] = newTag_o;
            strobe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock_i);
        #1;
    endtask

    task automatic set_miss(input logic [50:0] t, input logic [7:0] i, input logic [4:0] o);
        missValid_i  = 1'b1;
        missTag_i    = t;
        missIndex_i  = i;
        missOffset_i = o;
    endtask

    task automatic clr_miss();
        missValid_i = 1'b0;
    endtask

    function automatic logic [63:0] beat_data(input logic [7:0] b0, input int k);
        logic [7:0] bb;
        bb = b0 + 8'(k);
        return {8{bb}};
    endfunction

    function automatic logic [255:0] exp_line(input logic [7:0] b0);
        return {beat_data(b0, 0), beat_data(b0, 1), beat_data(b0, 2), beat_data(b0, 3)};
    endfunction

    function automatic logic [63:0] addr_of(input logic [50:0] t, input logic [7:0] i);
        return {t, i, 5'h00};
    endfunction

    // Four back-to-back beats; returns with the DUT in WRITE.
    task automatic refill(input logic [7:0] b0);
        for (int k = 0; k < 4; k++) begin
            memRespValid_i = 1'b1;
            memRespData_i  = beat_data(b0, k);
            cyc();
        end
        memRespValid_i = 1'b0;
    endtask

    // Accept the request the cycle after it appears.
    task automatic grant();
        memReqReady_i = 1'b1;
        cyc();
        memReqReady_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; missValid_i = 1'b0; missTag_i = '0; missIndex_i = '0;
        missOffset_i = '0; memReqReady_i = 1'b0; memRespValid_i = 1'b0; memRespData_i = '0;
        cyc(); cyc();
        reset_i = 1'b0; #1;
        check("rst_busy",   busy_o, 0);
        check("rst_reqv",   memReqValid_o, 0);
        check("rst_addr",   memReqAddr_o, 0);
        check("rst_upd",    cacheUpdateEnable_o, 0);
        check("rst_line",   newCacheline_o, 0);
        check("rst_drop",   missDropped_o, 0);

        // Single miss.
        set_miss(51'h1234, 8'h05, 5'h04); cyc(); clr_miss(); #1;
        check("t1_reqv", memReqValid_o, 1);
        check("t1_addr", memReqAddr_o, 64'h0000_0000_0246_80A0);
        grant(); #1;
        check("t1_reqv_resp", memReqValid_o, 0);
        check("t1_busy", busy_o, 1);
        refill(8'hA0); #1;
        check("t1_upd",   cacheUpdateEnable_o, 1);
        check("t1_line",  newCacheline_o, exp_line(8'hA0));
        check("t1_tag",   newTag_o, 51'h1234);
        check("t1_index", newIndex_o, 8'h05);
        check("t1_off",   newOffset_o, 5'h04);
        cyc(); #1;
        check("t1_upd_off",  cacheUpdateEnable_o, 0);
        check("t1_line_hold", newCacheline_o, exp_line(8'hA0));
        check("t1_idle", busy_o, 0);

        // Request backpressure for five cycles.
        set_miss(51'h55AA, 8'hFF, 5'h1F); cyc(); clr_miss(); #1;
        for (int i = 0; i < 5; i++) begin
            check("t2_reqv_hold", memReqValid_o, 1);
            check("t2_addr_hold", memReqAddr_o, addr_of(51'h55AA, 8'hFF));
            cyc(); #1;
        end
        check("t2_reqv_still", memReqValid_o, 1);
        grant(); #1;
        check("t2_resp", memReqValid_o, 0);
        refill(8'h10); #1;
        check("t2_line",  newCacheline_o, exp_line(8'h10));
        check("t2_index", newIndex_o, 8'hFF);
        check("t2_off",   newOffset_o, 5'h1F);
        cyc();

        // Merge, pending and drop.
        base = strobe_cnt;
        set_miss(51'h10, 8'h01, 5'h00); cyc(); clr_miss(); grant();
        memRespValid_i = 1'b1;
        set_miss(51'h10, 8'h01, 5'h02); memRespData_i = beat_data(8'h40, 0); #1;
        check("t3_merge_nodrop", missDropped_o, 0); cyc();
        set_miss(51'h20, 8'h02, 5'h03); memRespData_i = beat_data(8'h40, 1); #1;
        check("t3_pend_nodrop", missDropped_o, 0); cyc();
        set_miss(51'h30, 8'h03, 5'h00); memRespData_i = beat_data(8'h40, 2); #1;
        check("t3_drop", missDropped_o, 1); cyc();
        clr_miss(); memRespData_i = beat_data(8'h40, 3); #1;
        check("t3_drop_pulse", missDropped_o, 0); cyc();
        memRespValid_i = 1'b0; #1;
        check("t3_upd_a",  cacheUpdateEnable_o, 1);
        check("t3_tag_a",  newTag_o, 51'h10);
        check("t3_line_a", newCacheline_o, exp_line(8'h40));
        cyc(); #1;
        check("t3_req_b",  memReqValid_o, 1);
        check("t3_addr_b", memReqAddr_o, addr_of(51'h20, 8'h02));
        grant(); refill(8'h50); #1;
        check("t3_tag_b", newTag_o, 51'h20);
        check("t3_off_b", newOffset_o, 5'h03);
        cyc(); #1;
        check("t3_idle", busy_o, 0);
        check("t3_strobes", strobe_cnt - base, 2);

        // Drain of pending with a new distinct miss in the same WRITE cycle.
        base = strobe_cnt;
        set_miss(51'h100, 8'h11, 5'h01); cyc(); clr_miss(); grant();
        memRespValid_i = 1'b1;
        set_miss(51'h200, 8'h22, 5'h02); memRespData_i = beat_data(8'h60, 0); cyc();
        clr_miss();
        for (int k = 1; k < 4; k++) begin
            memRespData_i = beat_data(8'h60, k); cyc();
        end
        memRespValid_i = 1'b0;
        set_miss(51'h300, 8'h33, 5'h03); #1;
        check("t4_upd_a",   cacheUpdateEnable_o, 1);
        check("t4_nodrop",  missDropped_o, 0);
        cyc(); clr_miss(); #1;
        check("t4_addr_b", memReqAddr_o, addr_of(51'h200, 8'h22));
        grant(); refill(8'h70); #1;
        check("t4_tag_b", newTag_o, 51'h200);
        cyc(); #1;
        check("t4_reqv_d", memReqValid_o, 1);
        check("t4_addr_d", memReqAddr_o, addr_of(51'h300, 8'h33));
        grant(); refill(8'h80); #1;
        check("t4_tag_d",  newTag_o, 51'h300);
        check("t4_line_d", newCacheline_o, exp_line(8'h80));
        cyc(); #1;
        check("t4_idle", busy_o, 0);
        check("t4_strobes", strobe_cnt - base, 3);
        check("t4_order0", strobe_tags[base % 16], 51'h100);
        check("t4_order1", strobe_tags[(base + 1) % 16], 51'h200);
        check("t4_order2", strobe_tags[(base + 2) % 16], 51'h300);

        // Reset after two of four beats; the remaining beats must be ignored.
        base = strobe_cnt;
        set_miss(51'h400, 8'h44, 5'h04); cyc(); clr_miss(); grant();
        memRespValid_i = 1'b1;
        memRespData_i = beat_data(8'h90, 0); cyc();
        memRespData_i = beat_data(8'h90, 1); cyc();
        memRespValid_i = 1'b0;
        reset_i = 1'b1; cyc(); reset_i = 1'b0;
        memRespValid_i = 1'b1;
        memRespData_i = beat_data(8'h90, 2); cyc();
        memRespData_i = beat_data(8'h90, 3); cyc();
        memRespValid_i = 1'b0; #1;
        check("t5_busy",    busy_o, 0);
        check("t5_upd",     cacheUpdateEnable_o, 0);
        check("t5_reqv",    memReqValid_o, 0);
        check("t5_addr",    memReqAddr_o, 0);
        check("t5_line",    newCacheline_o, 0);
        check("t5_tag",     newTag_o, 0);
        check("t5_strobes", strobe_cnt - base, 0);
        set_miss(51'h500, 8'h55, 5'h05); cyc(); clr_miss(); grant();
        refill(8'hB0); #1;
        check("t5_fresh_line", newCacheline_o, exp_line(8'hB0));
        check("t5_fresh_tag",  newTag_o, 51'h500);
        cyc();

        // Stray beats while idle.
        memRespValid_i = 1'b1;
        memRespData_i  = 64'hFFFF_FFFF_FFFF_FFFF;
        cyc(); cyc(); cyc();
        memRespValid_i = 1'b0; #1;
        check("t6_busy", busy_o, 0);
        check("t6_reqv", memReqValid_o, 0);
        check("t6_line_hold", newCacheline_o, exp_line(8'hB0));
        set_miss(51'h600, 8'h66, 5'h06); cyc(); clr_miss(); grant();
        refill(8'hC0); #1;
        check("t6_line", newCacheline_o, exp_line(8'hC0));
        check("t6_tag",  newTag_o, 51'h600);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
